id_ex_interlock: RTL and testbench

- Pipeline register between Decode (D) and Execute (X) of the 5-stage MIPS core.
- Contains the interlock logic that decides when to stall the fetch and decode stages.
- Captures D-stage operands and control fields, and produces the x_rs/x_rt/x_writeReg/x_WB values that the forwarding unit consumes.
- Detects load-use and branch-operand hazards, freezes PC and IF/ID, and inserts bubbles. It also keeps stall statistics and a stall watchdog.

---
 rtl/id_ex_interlock.sv | 138 +++++++++++++
 tb/tb_id_ex_interlock.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_interlock.sv
// id_ex_interlock: Decode→Execute pipeline register plus the hazard interlock.
//
// It registers the D-stage operands and control into the X stage. It holds PC
// and IF/ID when a load-use hazard or a branch-operand hazard is seen. Each
// hazard or flush puts a bubble into X. It also keeps saturating statistics
// and a sticky watchdog that trips on long stalls.
//
// Ports
//   clk, pc_rst          clock, async active-high reset
//   d_*                  D-stage instruction fields, operands and control
//   flush                taken branch/jump; kills the D instruction
//   m_writeReg/RW/MemRead M-stage destination info, used for branch hazards
//   x_*                  X-stage registered instruction
//   stall                combinational hold for PC and IF/ID
//   bubble_cnt/stall_cnt saturating statistics counters
//   hazard_err           sticky: MAX_STALL consecutive stall cycles were seen
module id_ex_interlock #(
  parameter int DW        = 32,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             pc_rst,
  input  logic             d_valid,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [4:0]       d_rd,
  input  logic             d_uses_rt,
  input  logic             d_is_branch,
  input  logic [DW-1:0]    d_rs_data,
  input  logic [DW-1:0]    d_rt_data,
  input  logic [DW-1:0]    d_imm,
  input  logic [1:0]       d_WB,
  input  logic [1:0]       d_M,
  input  logic [3:0]       d_EX,
  input  logic             d_RegDst,
  input  logic             flush,
  input  logic [4:0]       m_writeReg,
  input  logic             m_RW,
  input  logic             m_MemRead,
  output logic             x_valid,
  output logic [4:0]       x_rs,
  output logic [4:0]       x_rt,
  output logic [4:0]       x_writeReg,
  output logic [DW-1:0]    x_rs_data,
  output logic [DW-1:0]    x_rt_data,
  output logic [DW-1:0]    x_imm,
  output logic [1:0]       x_WB,
  output logic [1:0]       x_M,
  output logic [3:0]       x_EX,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             hazard_err
);

  localparam int RUN_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [4:0]       d_wr;
  logic             lu, br, src_x, src_m, bubble;
  logic [RUN_W-1:0] run;

  // A nonzero producer register matches a D source operand.
  function automatic logic reads(input logic [4:0] r, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  always_comb begin
    d_wr   = d_RegDst ? d_rd : d_rt;
    lu     = d_valid & x_valid & x_M[0] & reads(x_writeReg, d_rs, d_rt, d_uses_rt);
    // A branch compares in D, so it has to wait for any ALU result still in X,
    // and for load data still in M.
    src_x  = x_valid & x_WB[0] & reads(x_writeReg, d_rs, d_rt, d_uses_rt);
    src_m  = m_RW & m_MemRead & reads(m_writeReg, d_rs, d_rt, d_uses_rt);
    br     = d_valid & d_is_branch & (src_x | src_m);
    // A flush wins over a hazard: the stalled instruction dies anyway, and
    // fetch must move on to the target.
    stall  = (lu | br) & ~flush & ~pc_rst;
    bubble = flush | stall;
  end

  // X-stage register
  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      x_valid    <= 1'b0;
      x_rs       <= '0;
      x_rt       <= '0;
      x_writeReg <= '0;
      x_rs_data  <= '0;
      x_rt_data  <= '0;
      x_imm      <= '0;
      x_WB       <= '0;
      x_M        <= '0;
      x_EX       <= '0;
    end else if (bubble) begin
      // Only valid and control are cleared. With x_WB[0]=0, the stale
      // register fields cannot produce a forwarding match.
      x_valid <= 1'b0;
      x_WB    <= '0;
      x_M     <= '0;
      x_EX    <= '0;
    end else begin
      x_valid    <= d_valid;
      x_rs       <= d_rs;
      x_rt       <= d_rt;
      x_writeReg <= d_wr;
      x_rs_data  <= d_rs_data;
      x_rt_data  <= d_rt_data;
      x_imm      <= d_imm;
      x_WB       <= d_WB;
      x_M        <= d_M;
      x_EX       <= d_EX;
    end
  end

  // Statistics and watchdog
  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
      run        <= '0;
      hazard_err <= 1'b0;
    end else begin
      if (bubble && bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (stall && stall_cnt != CNT_MAX)   stall_cnt  <= stall_cnt + CNT_W'(1);
      if (stall) begin
        if (run != RUN_W'(MAX_STALL)) run <= run + RUN_W'(1);
        // This edge completes the MAX_STALL-th consecutive stall cycle.
        if (run >= RUN_W'(MAX_STALL - 1)) hazard_err <= 1'b1;
      end else begin
        run <= '0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_interlock.sv
// Scoreboard bench for id_ex_interlock. A driver applies stimulus just after
// each rising edge. It pushes the expected X state and the expected stall,
// taken from a reference model of the pipeline rules. A monitor pops each
// entry on the falling edge and compares it.
module tb_id_ex_interlock;
  localparam int DW = 32, CNT_W = 6, MAX_STALL = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic pc_rst, d_valid, d_uses_rt, d_is_branch, d_RegDst, flush, m_RW, m_MemRead;
  logic [4:0] d_rs, d_rt, d_rd, m_writeReg;
  logic [DW-1:0] d_rs_data, d_rt_data, d_imm;
  logic [1:0] d_WB, d_M;
  logic [3:0] d_EX;
  logic x_valid, stall, hazard_err;
  logic [4:0] x_rs, x_rt, x_writeReg;
  logic [DW-1:0] x_rs_data, x_rt_data, x_imm;
  logic [1:0] x_WB, x_M;
  logic [3:0] x_EX;
  logic [CNT_W-1:0] bubble_cnt, stall_cnt;

  always #5 clk = ~clk;

  id_ex_interlock #(.DW(DW), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .pc_rst(pc_rst), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_rd(d_rd), .d_uses_rt(d_uses_rt), .d_is_branch(d_is_branch),
    .d_rs_data(d_rs_data), .d_rt_data(d_rt_data), .d_imm(d_imm), .d_WB(d_WB),
    .d_M(d_M), .d_EX(d_EX), .d_RegDst(d_RegDst), .flush(flush),
    .m_writeReg(m_writeReg), .m_RW(m_RW), .m_MemRead(m_MemRead),
    .x_valid(x_valid), .x_rs(x_rs), .x_rt(x_rt), .x_writeReg(x_writeReg),
    .x_rs_data(x_rs_data), .x_rt_data(x_rt_data), .x_imm(x_imm), .x_WB(x_WB),
    .x_M(x_M), .x_EX(x_EX), .stall(stall), .bubble_cnt(bubble_cnt),
    .stall_cnt(stall_cnt), .hazard_err(hazard_err));

  typedef struct {
    logic vld; logic [4:0] rs, rt, rd; logic uses_rt, br, regdst, flush;
    logic [DW-1:0] a, b, imm; logic [1:0] wb, m; logic [3:0] ex;
    logic m_auto; logic [4:0] m_wr; logic m_rw, m_mr; logic rst;
  } stim_t;

  typedef struct {
    logic vld; logic [4:0] rs, rt, wr; logic [DW-1:0] a, b, imm;
    logic [1:0] wb, m; logic [3:0] ex;
    int bcnt, scnt, run; logic err;
  } xs_t;

  typedef struct { xs_t x; logic stall; } exp_t;

  exp_t q[$];
  xs_t  cur, prev;
  int   n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic xs_t zero_x();
    xs_t z;
    z = '{vld: 1'b0, rs: '0, rt: '0, wr: '0, a: '0, b: '0, imm: '0,
          wb: '0, m: '0, ex: '0, bcnt: 0, scnt: 0, run: 0, err: 1'b0};
    return z;
  endfunction

  // ---------------- reference model ----------------
  function automatic bit src_of(input logic [4:0] r, input stim_t s);
    return r != 0 && (r == s.rs || (s.uses_rt && r == s.rt));
  endfunction

  function automatic bit want_stall(input xs_t x, input stim_t s);
    bit load_use, branch_dep;
    if (s.rst) return 1'b0;
    load_use   = s.vld && x.vld && x.m[0] && src_of(x.wr, s);
    branch_dep = s.vld && s.br &&
                 ((x.vld && x.wb[0] && src_of(x.wr, s)) ||
                  (s.m_rw && s.m_mr && src_of(s.m_wr, s)));
    return (load_use || branch_dep) && !s.flush;
  endfunction

  function automatic xs_t next_x(input xs_t x, input stim_t s);
    xs_t n = x;
    bit st = want_stall(x, s);
    if (s.flush || st) begin
      n.vld = 0; n.wb = 0; n.m = 0; n.ex = 0;
      n.bcnt = (x.bcnt < CMAX) ? x.bcnt + 1 : CMAX;
    end else begin
      n.vld = s.vld; n.rs = s.rs; n.rt = s.rt; n.wr = s.regdst ? s.rd : s.rt;
      n.a = s.a; n.b = s.b; n.imm = s.imm; n.wb = s.wb; n.m = s.m; n.ex = s.ex;
    end
    if (st) begin
      n.scnt = (x.scnt < CMAX) ? x.scnt + 1 : CMAX;
      n.run  = x.run + 1;
      if (n.run >= MAX_STALL) n.err = 1;
    end else n.run = 0;
    return n;
  endfunction

  // ---------------- stimulus builders ----------------
  function automatic stim_t nop();
    stim_t s;
    s = '{vld: 0, rs: '0, rt: '0, rd: '0, uses_rt: 0, br: 0, regdst: 0, flush: 0,
          a: $urandom, b: $urandom, imm: $urandom, wb: '0, m: '0, ex: '0,
          m_auto: 1, m_wr: '0, m_rw: 0, m_mr: 0, rst: 0};
    return s;
  endfunction
  function automatic stim_t alu(input int rd, input int rs, input int rt);
    stim_t s = nop();
    s.vld = 1; s.rd = 5'(rd); s.rs = 5'(rs); s.rt = 5'(rt); s.uses_rt = 1;
    s.regdst = 1; s.wb = 2'b01; s.ex = 4'b0100;
    return s;
  endfunction
  function automatic stim_t lw(input int rt, input int rs);
    stim_t s = nop();
    s.vld = 1; s.rt = 5'(rt); s.rs = 5'(rs); s.rd = 5'($urandom_range(0, 31));
    s.wb = 2'b11; s.m = 2'b01; s.ex = 4'b0001;
    return s;
  endfunction
  function automatic stim_t beq(input int rs, input int rt);
    stim_t s = nop();
    s.vld = 1; s.rs = 5'(rs); s.rt = 5'(rt); s.uses_rt = 1; s.br = 1;
    return s;
  endfunction

  // Drive one cycle. The M stage is whatever sat in X one edge earlier,
  // unless the stimulus overrides it.
  task automatic apply(input stim_t s_in);
    stim_t s = s_in;
    exp_t  e;
    xs_t   nx;
    @(posedge clk); #1;
    if (s.m_auto) begin
      s.m_wr = prev.wr; s.m_rw = prev.vld & prev.wb[0]; s.m_mr = prev.vld & prev.m[0];
    end
    pc_rst = s.rst; d_valid = s.vld; d_rs = s.rs; d_rt = s.rt; d_rd = s.rd;
    d_uses_rt = s.uses_rt; d_is_branch = s.br; d_RegDst = s.regdst; flush = s.flush;
    d_rs_data = s.a; d_rt_data = s.b; d_imm = s.imm; d_WB = s.wb; d_M = s.m; d_EX = s.ex;
    m_writeReg = s.m_wr; m_RW = s.m_rw; m_MemRead = s.m_mr;
    if (s.rst) begin cur = zero_x(); prev = zero_x(); end
    e.x = cur; e.stall = want_stall(cur, s);
    q.push_back(e);
    nx = s.rst ? zero_x() : next_x(cur, s);
    prev = s.rst ? zero_x() : cur;
    cur = nx;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("x_valid", 128'(x_valid), 128'(e.x.vld));
        chk("x_ctrl", 128'({x_WB, x_M, x_EX}), 128'({e.x.wb, e.x.m, e.x.ex}));
        if (e.x.vld) begin
          chk("x_regs", 128'({x_rs, x_rt, x_writeReg}), 128'({e.x.rs, e.x.rt, e.x.wr}));
          chk("x_data", 128'({x_rs_data, x_rt_data, x_imm}), 128'({e.x.a, e.x.b, e.x.imm}));
        end
        chk("stall", 128'(stall), 128'(e.stall));
        chk("bubble_cnt", 128'(bubble_cnt), 128'(e.x.bcnt));
        chk("stall_cnt", 128'(stall_cnt), 128'(e.x.scnt));
        chk("hazard_err", 128'(hazard_err), 128'(e.x.err));
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    stim_t s;
    int op;
    cur = zero_x(); prev = zero_x();
    pc_rst = 1; d_valid = 0; d_rs = 0; d_rt = 0; d_rd = 0; d_uses_rt = 0;
    d_is_branch = 0; d_RegDst = 0; flush = 0; d_rs_data = 0; d_rt_data = 0;
    d_imm = 0; d_WB = 0; d_M = 0; d_EX = 0; m_writeReg = 0; m_RW = 0; m_MemRead = 0;
    s = nop(); s.rst = 1; apply(s);           // reset state
    apply(nop());

    // load-use: 1 stall, then the add is captured
    apply(lw(8, 1)); apply(alu(9, 8, 2)); apply(alu(9, 8, 2)); apply(nop());
    // ALU then branch: 1 stall
    apply(alu(5, 1, 2)); apply(beq(5, 3)); apply(beq(5, 3)); apply(nop());
    // load then branch: 2 stalls
    apply(lw(5, 1)); apply(beq(5, 3)); apply(beq(5, 3)); apply(beq(5, 3)); apply(nop());
    // $zero is never a hazard
    apply(lw(0, 1)); apply(alu(6, 0, 0)); apply(nop());
    // flush together with a load-use hazard
    apply(lw(8, 1)); s = alu(9, 8, 2); s.flush = 1; apply(s); apply(nop());
    // reset in the middle of a stall cycle, then a normal capture
    apply(lw(8, 1)); apply(alu(9, 8, 2));
    s = alu(9, 8, 2); s.rst = 1; apply(s);
    apply(alu(9, 8, 2)); apply(nop());

    // Held branch hazard trips the watchdog and saturates the counters.
    s = beq(7, 3); s.m_auto = 0; s.m_wr = 7; s.m_rw = 1; s.m_mr = 1;
    repeat (CMAX + 6) apply(s);
    repeat (3) apply(nop());                  // hazard_err stays sticky
    s = nop(); s.rst = 1; apply(s);

    // randomized traffic over a few registers so hazards are frequent
    repeat (500) begin
      op = $urandom_range(0, 5);
      case (op)
        0:       s = nop();
        1, 2:    s = lw($urandom_range(0, 3), $urandom_range(0, 3));
        3:       s = alu($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        4:       s = beq($urandom_range(0, 3), $urandom_range(0, 3));
        default: begin
          s = alu($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
          s.uses_rt = 1'($urandom); s.regdst = 1'($urandom); s.m = 2'($urandom);
          s.wb = 2'($urandom); s.ex = 4'($urandom); s.br = 1'($urandom);
        end
      endcase
      s.flush = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 4) == 0) begin
        s.m_auto = 0; s.m_wr = 5'($urandom_range(0, 3));
        s.m_rw = 1'($urandom); s.m_mr = 1'($urandom);
      end
      s.rst = ($urandom_range(0, 99) == 0);
      apply(s);
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
